// File: rtl/uart_cfg_sequencer.sv
// Round-robin sharer of the UART config-register port: latches the winning requester's
// payload and replays it as single-cycle cfg_en writes to ctrl (0x00), isr (0x04) and cd (0x08).
module uart_cfg_sequencer #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [3*N_REQ-1:0]         req_mask_i,
  input  logic [7*N_REQ-1:0]         req_ctrl_i,
  input  logic [2*N_REQ-1:0]         req_isr_i,
  input  logic [20*N_REQ-1:0]        req_baud_i,
  output logic [7:0]                 PADDR,
  output logic                       cfg_en,
  output logic [6:0]                 ctrl_o,
  output logic [3:0]                 state_isr_o,
  output logic [19:0]                desired_baud_rate,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(N_REQ)-1:0]   grant_id_o
);

  localparam int unsigned GW    = $clog2(N_REQ);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;

  state_t           state;
  logic [2:0]       mask_q;
  logic [GW-1:0]    rr_ptr;
  logic [CNT_W-1:0] gap_cnt;

  logic             grant_vld_c;
  logic [GW-1:0]    grant_c;
  logic [2:0]       sel_mask_c;
  logic [6:0]       sel_ctrl_c;
  logic [1:0]       sel_isr_c;
  logic [19:0]      sel_baud_c;
  logic [7:0]       offset_c;
  logic [2:0]       remain_c;

  // First valid requester at or after the round-robin pointer, cyclically
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_vld_c = 1'b0;
    grant_c     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_vld_c && req_valid_i[GW'(idx)]) begin
        grant_vld_c = 1'b1;
        grant_c     = GW'(idx);
      end
    end
  end

  // Payload mux for the granted requester
  always_comb begin
    sel_mask_c = '0;
    sel_ctrl_c = '0;
    sel_isr_c  = '0;
    sel_baud_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c == GW'(i)) begin
        sel_mask_c = req_mask_i[i*3 +: 3];
        sel_ctrl_c = req_ctrl_i[i*7 +: 7];
        sel_isr_c  = req_isr_i[i*2 +: 2];
        sel_baud_c = req_baud_i[i*20 +: 20];
      end
    end
  end

  // Lowest pending mask bit selects the register offset
  always_comb begin
    offset_c = 8'h08;
    remain_c = mask_q & 3'b011;
    if (mask_q[0]) begin
      offset_c = 8'h00;
      remain_c = mask_q & 3'b110;
    end else if (mask_q[1]) begin
      offset_c = 8'h04;
      remain_c = mask_q & 3'b100;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state             <= IDLE;
      mask_q            <= '0;
      rr_ptr            <= '0;
      gap_cnt           <= '0;
      req_ready_o       <= '0;
      PADDR             <= 8'h00;
      cfg_en            <= 1'b0;
      ctrl_o            <= 7'b000_0011;
      state_isr_o       <= 4'h0;
      desired_baud_rate <= 20'd115200;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      grant_id_o        <= '0;
    end else begin
      req_ready_o <= '0;
      cfg_en      <= 1'b0;
      done_o      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_vld_c) begin
            req_ready_o       <= N_REQ'(1) << grant_c;
            grant_id_o        <= grant_c;
            mask_q            <= sel_mask_c;
            ctrl_o            <= sel_ctrl_c;
            state_isr_o       <= {sel_isr_c, 2'b00};
            desired_baud_rate <= sel_baud_c;
            busy_o            <= 1'b1;
            state             <= (sel_mask_c == 3'b000) ? DONE : WRITE;
          end
        end
        WRITE: begin
          cfg_en <= 1'b1;
          PADDR  <= offset_c;
          mask_q <= remain_c;
          if (remain_c == 3'b000) begin
            state <= DONE;
          end else if (SETTLE_CYC == 0) begin
            state <= WRITE;
          end else begin
            gap_cnt <= CNT_W'(SETTLE_CYC - 1);
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= WRITE;
          else               gap_cnt <= gap_cnt - CNT_W'(1);
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          rr_ptr <= (grant_id_o == GW'(N_REQ - 1)) ? '0 : grant_id_o + GW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Randomized bench for uart_cfg_sequencer against a transaction-level schedule model.
module tb_uart_cfg_sequencer;

  localparam int N  = 2;
  localparam int S  = 2;
  localparam int GW = $clog2(N);

  logic CLK = 1'b0;
  logic RESET;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [3*N-1:0]  req_mask;
  logic [7*N-1:0]  req_ctrl;
  logic [2*N-1:0]  req_isr;
  logic [20*N-1:0] req_baud;
  logic [7:0]      paddr;
  logic            cfg_en;
  logic [6:0]      ctrl;
  logic [3:0]      state_isr;
  logic [19:0]     baud;
  logic            busy;
  logic            done;
  logic [GW-1:0]   gid;

  logic [2:0]  pl_mask [N];
  logic [6:0]  pl_ctrl [N];
  logic [1:0]  pl_isr  [N];
  logic [19:0] pl_baud [N];

  int checks    = 0;
  int failures  = 0;
  int model_ptr = 0;
  bit saw_r1    = 1'b0;

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_mask[i*3 +: 3]   = pl_mask[i];
      req_ctrl[i*7 +: 7]   = pl_ctrl[i];
      req_isr[i*2 +: 2]    = pl_isr[i];
      req_baud[i*20 +: 20] = pl_baud[i];
    end
  end

  always @(negedge CLK) if (req_ready[1]) saw_r1 = 1'b1;

  uart_cfg_sequencer #(.N_REQ(N), .SETTLE_CYC(S)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_mask_i        (req_mask),
    .req_ctrl_i        (req_ctrl),
    .req_isr_i         (req_isr),
    .req_baud_i        (req_baud),
    .PADDR             (paddr),
    .cfg_en            (cfg_en),
    .ctrl_o            (ctrl),
    .state_isr_o       (state_isr),
    .desired_baud_rate (baud),
    .busy_o            (busy),
    .done_o            (done),
    .grant_id_o        (gid)
  );

  task automatic randomize_pl(input int i);
    pl_mask[i] = 3'($urandom);
    pl_ctrl[i] = 7'($urandom);
    pl_isr[i]  = 2'($urandom);
    pl_baud[i] = 20'($urandom);
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (model_ptr + i) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Called at the negedge of the accept cycle; walks the whole expected schedule
  task automatic follow_txn(input int g, input logic [2:0] m, input logic [6:0] c,
                            input logic [1:0] is, input logic [19:0] b, input logic [N-1:0] keep);
    logic [N-1:0] exp_rdy;
    logic [30:0]  exp_data;
    logic [7:0]   offs[$];
    int n, done_at, slot;
    bit exp_en;
    exp_rdy    = '0;
    exp_rdy[g] = 1'b1;
    exp_data   = {c, is, 2'b00, b};
    checks++;
    if (req_ready !== exp_rdy || gid !== GW'(g)) begin
      failures++;
      $display("FAIL accept_grant: ready=%b gid=%0d, expected ready=%b gid=%0d", req_ready, gid, exp_rdy, g);
    end
    checks++;
    if ({ctrl, state_isr, baud} !== exp_data || busy !== 1'b1) begin
      failures++;
      $display("FAIL accept_latch: data=%h busy=%b, expected data=%h busy=1", {ctrl, state_isr, baud}, busy, exp_data);
    end
    req_valid = req_valid & keep;
    randomize_pl(g);
    n = 0;
    for (int bi = 0; bi < 3; bi++) if (m[bi]) begin offs.push_back(8'(bi * 4)); n++; end
    done_at = (n == 0) ? 1 : 2 + (n - 1) * (S + 1);
    for (int k = 1; k <= done_at; k++) begin
      @(negedge CLK);
      slot   = k - 1;
      exp_en = (n > 0) && (slot % (S + 1) == 0) && (slot / (S + 1) < n);
      checks++;
      if (cfg_en !== exp_en || (exp_en && paddr !== offs[slot / (S + 1)])) begin
        failures++;
        $display("FAIL write_slot T+%0d mask=%b: cfg_en=%b PADDR=%h, expected cfg_en=%b", k, m, cfg_en, paddr, exp_en);
      end
      checks++;
      if (done !== (k == done_at) || busy !== (k != done_at)) begin
        failures++;
        $display("FAIL done_busy T+%0d: done=%b busy=%b, expected done=%b busy=%b", k, done, busy, k == done_at, k != done_at);
      end
      checks++;
      if (req_ready !== '0 || {ctrl, state_isr, baud} !== exp_data) begin
        failures++;
        $display("FAIL hold T+%0d: ready=%b data=%h, expected ready=0 data=%h", k, req_ready, {ctrl, state_isr, baud}, exp_data);
      end
    end
    model_ptr = (g + 1) % N;
  endtask

  task automatic do_txn(input logic [N-1:0] keep, output int g, output int waited);
    logic [2:0] m; logic [6:0] c; logic [1:0] is; logic [19:0] b;
    bit ok;
    g = model_grant(req_valid);
    waited = 0;
    if (g < 0) return;
    m = pl_mask[g]; c = pl_ctrl[g]; is = pl_isr[g]; b = pl_baud[g];
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      waited++;
      if (req_ready !== '0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: no ready within 40 cycles, expected grant %0d", g);
    end else begin
      follow_txn(g, m, c, is, b, keep);
    end
  endtask

  task automatic test_reset;
    RESET     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) randomize_pl(i);
    repeat (3) @(negedge CLK);
    checks++;
    if ({req_ready, paddr, cfg_en, ctrl, state_isr, baud, busy, done, gid} !==
        {{N{1'b0}}, 8'h00, 1'b0, 7'b000_0011, 4'h0, 20'd115200, 1'b0, 1'b0, {GW{1'b0}}}) begin
      failures++;
      $display("FAIL reset_values: ready=%b PADDR=%h en=%b ctrl=%h isr=%h baud=%0d busy=%b done=%b gid=%0d",
               req_ready, paddr, cfg_en, ctrl, state_isr, baud, busy, done, gid);
    end
    RESET = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      checks++;
      if (cfg_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: en=%b done=%b busy=%b, expected all 0", k, cfg_en, done, busy);
      end
    end
    model_ptr = 0;
  endtask

  task automatic test_full_mask;
    int g, w;
    pl_mask[0] = 3'b111; pl_ctrl[0] = 7'h15; pl_isr[0] = 2'b10; pl_baud[0] = 20'd9600;
    req_valid  = 2'b01;
    do_txn('0, g, w);
  endtask

  task automatic test_round_robin;
    int g, w;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < N; i++) randomize_pl(i);
    req_valid = '1;
    for (int t = 0; t < 4; t++) begin
      do_txn((t == 3) ? N'(0) : '1, g, w);
      if (t > 0) begin
        checks++;
        if (w !== 1) begin
          failures++;
          $display("FAIL rr_back_to_back txn %0d: accept %0d cycles after done, expected 1", t, w);
        end
      end
    end
  endtask

  task automatic test_single_and_empty;
    int g, w;
    randomize_pl(1);
    pl_mask[1] = 3'b100;
    req_valid  = 2'b10;
    do_txn('0, g, w);
    randomize_pl(0);
    pl_mask[0] = 3'b000;
    req_valid  = 2'b01;
    do_txn('0, g, w);
  endtask

  task automatic test_reset_mid;
    int g, w;
    bit ok;
    randomize_pl(0);
    pl_mask[0] = 3'b111;
    req_valid  = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (req_ready[0] === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL abort_accept: req0 never accepted, expected accept");
    end
    req_valid = '0;
    @(negedge CLK);
    checks++;
    if (cfg_en !== 1'b1 || paddr !== 8'h00) begin
      failures++;
      $display("FAIL abort_first_write: en=%b PADDR=%h, expected en=1 PADDR=00", cfg_en, paddr);
    end
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++;
    if ({cfg_en, busy, done, gid} !== '0) begin
      failures++;
      $display("FAIL abort_async: en=%b busy=%b done=%b gid=%0d, expected all 0", cfg_en, busy, done, gid);
    end
    @(negedge CLK);
    RESET = 1'b0;
    model_ptr = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      checks++;
      if (cfg_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet cycle %0d: en=%b done=%b busy=%b, expected all 0", k, cfg_en, done, busy);
      end
    end
    for (int i = 0; i < N; i++) randomize_pl(i);
    req_valid = '1;
    do_txn('0, g, w);
  endtask

  task automatic test_drop;
    logic [2:0] m; logic [6:0] c; logic [1:0] is; logic [19:0] b;
    bit ok;
    saw_r1 = 1'b0;
    randomize_pl(0);
    pl_mask[0] = 3'b111;
    m = pl_mask[0]; c = pl_ctrl[0]; is = pl_isr[0]; b = pl_baud[0];
    req_valid = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (req_ready !== '0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drop_accept: req0 never accepted, expected accept");
    end else begin
      fork
        follow_txn(0, m, c, is, b, 2'b10);
        begin
          req_valid[1] = 1'b1;
          repeat (3) @(negedge CLK);
          req_valid[1] = 1'b0;
        end
      join
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      checks++;
      if (req_ready !== '0 || cfg_en !== 1'b0) begin
        failures++;
        $display("FAIL drop_quiet cycle %0d: ready=%b en=%b, expected 0", k, req_ready, cfg_en);
      end
    end
    checks++;
    if (saw_r1 !== 1'b0) begin
      failures++;
      $display("FAIL drop_no_ready1: ready[1] pulsed=%b, expected 0", saw_r1);
    end
  endtask

  task automatic test_random;
    int g, w;
    logic [N-1:0] newv;
    for (int it = 0; it < 24; it++) begin
      newv = N'($urandom);
      if (newv == '0) newv[$urandom % N] = 1'b1;
      req_valid = req_valid | newv;
      do_txn(N'($urandom), g, w);
    end
    req_valid = '0;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_mask();
    test_round_robin();
    test_single_and_empty();
    test_reset_mid();
    test_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
